// File: rtl/q_tile_scheduler_pkg.sv
// Shared types for the Q-tile scheduler: fetch/compute FSM encodings and row sizing.
package q_tile_scheduler_pkg;

  typedef enum logic [0:0] {
    FIdle,
    FReq
  } fetch_state_t;

  typedef enum logic [2:0] {
    CIdle,
    CWaitFull,
    CLatch,
    CLaunch,
    CRun,
    CRelease,
    CFinish
  } compute_state_t;

  // Bytes per Q row; rows are packed back to back in memory.
  function automatic int unsigned row_bytes(input int unsigned q_width);
    return q_width / 8;
  endfunction

endpackage

// File: rtl/q_fetch_agu.sv
// Fetch FSM and address generator: issues Q-row reads, at most two tiles ahead of retirement.
module q_fetch_agu
  import q_tile_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PES    = 4,
  parameter int unsigned Q_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TILE_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_go,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [TILE_W-1:0]     num_tiles,
  input  logic [TILE_W-1:0]     tiles_ret,
  input  logic                  mem_req_ready,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr
);

  localparam int unsigned RowsW   = TILE_W + $clog2(NUM_PES);
  localparam int unsigned RowCntW = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;
  localparam logic [RowCntW-1:0]    LastRow  = RowCntW'(NUM_PES - 1);
  localparam logic [ADDR_WIDTH-1:0] RowBytes = ADDR_WIDTH'(row_bytes(Q_WIDTH));

  fetch_state_t         state_q, state_d;
  logic [RowsW-1:0]     rows_q, rows_d;
  logic [RowCntW-1:0]   row_cnt_q, row_cnt_d;
  logic [TILE_W-1:0]    tiles_req_q, tiles_req_d;
  logic [TILE_W-1:0]    outstanding;
  logic                 credit_ok;
  logic                 req_fire;

  // Credit uses registered counts only, so a retire frees credit one cycle later.
  assign outstanding = tiles_req_q - tiles_ret;
  assign credit_ok   = outstanding < TILE_W'(2);
  assign req_fire    = mem_req_valid && mem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FIdle;
      rows_q      <= '0;
      row_cnt_q   <= '0;
      tiles_req_q <= '0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      row_cnt_q   <= row_cnt_d;
      tiles_req_q <= tiles_req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    row_cnt_d   = row_cnt_q;
    tiles_req_d = tiles_req_q;
    unique case (state_q)
      FIdle: begin
        if (start_go) begin
          state_d     = FReq;
          rows_d      = '0;
          row_cnt_d   = '0;
          tiles_req_d = '0;
        end
      end
      FReq: begin
        if (req_fire) begin
          rows_d = rows_q + RowsW'(1);
          if (row_cnt_q == LastRow) begin
            row_cnt_d   = '0;
            tiles_req_d = tiles_req_q + TILE_W'(1);
            if (tiles_req_d == num_tiles) begin
              state_d = FIdle;
            end
          end else begin
            row_cnt_d = row_cnt_q + RowCntW'(1);
          end
        end
      end
      default: state_d = FIdle;
    endcase
  end

  always_comb begin
    mem_req_valid = (state_q == FReq) && credit_ok;
    mem_req_addr  = base_addr + ADDR_WIDTH'(rows_q) * RowBytes;
  end

endmodule

// File: rtl/q_tile_scheduler.sv
// Q-tile scheduler top: compute FSM, response pass-through into the Q buffer, bank-order check.
module q_tile_scheduler
  import q_tile_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PES    = 4,
  parameter int unsigned Q_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TILE_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] q_base_addr,
  input  logic [TILE_W-1:0]     num_q_tiles,
  output logic                  busy,
  output logic                  done,
  output logic                  order_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [Q_WIDTH-1:0]    mem_rsp_data,
  output logic                  buf_load_valid,
  input  logic                  buf_load_ready,
  output logic [Q_WIDTH-1:0]    buf_load_data,
  output logic                  buf_compute_start,
  output logic                  buf_compute_done,
  input  logic                  buf_bank_full,
  input  logic                  buf_bank_active,
  input  logic                  buf_active_bank_id,
  output logic                  pe_tile_start,
  input  logic                  pe_tile_done,
  output logic [TILE_W-1:0]     pe_tile_idx
);

  compute_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [TILE_W-1:0]       num_q;
  logic [TILE_W-1:0]       tiles_ret_q;
  logic                    order_err_q;
  logic                    start_acc;
  logic                    fetch_go;
  logic                    tile_last;
  logic                    unused_bank_active;

  assign start_acc          = start && (state_q == CIdle);
  assign fetch_go           = start_acc && (num_q_tiles != '0);
  assign tile_last          = (tiles_ret_q + TILE_W'(1)) == num_q;
  assign unused_bank_active = buf_bank_active;

  q_fetch_agu #(
    .NUM_PES    (NUM_PES),
    .Q_WIDTH    (Q_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .TILE_W     (TILE_W)
  ) u_fetch_agu (
    .clk           (clk),
    .rst           (rst),
    .start_go      (fetch_go),
    .base_addr     (base_q),
    .num_tiles     (num_q),
    .tiles_ret     (tiles_ret_q),
    .mem_req_ready (mem_req_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      num_q       <= '0;
      tiles_ret_q <= '0;
      order_err_q <= 1'b0;
    end else begin
      if (start_acc) begin
        base_q      <= q_base_addr;
        num_q       <= num_q_tiles;
        tiles_ret_q <= '0;
        order_err_q <= 1'b0;
      end
      if (state_q == CRelease) begin
        tiles_ret_q <= tiles_ret_q + TILE_W'(1);
      end
      // Banks alternate, so tile parity must match the bank the buffer latched.
      if ((state_q == CLaunch) && (buf_active_bank_id != tiles_ret_q[0])) begin
        order_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CIdle:     if (start_acc) state_d = (num_q_tiles == '0) ? CFinish : CWaitFull;
      CWaitFull: if (buf_bank_full) state_d = CLatch;
      CLatch:    state_d = CLaunch;
      CLaunch:   state_d = CRun;
      CRun:      if (pe_tile_done) state_d = CRelease;
      CRelease:  state_d = tile_last ? CFinish : CWaitFull;
      CFinish:   state_d = CIdle;
      default:   state_d = CIdle;
    endcase
  end

  always_comb begin
    busy              = (state_q != CIdle);
    done              = (state_q == CFinish);
    buf_compute_start = (state_q == CLatch);
    pe_tile_start     = (state_q == CLaunch);
    buf_compute_done  = (state_q == CRelease);
    pe_tile_idx       = tiles_ret_q;
    order_err         = order_err_q;
    buf_load_valid    = mem_rsp_valid & busy;
    buf_load_data     = mem_rsp_data;
    mem_rsp_ready     = buf_load_ready & busy;
  end

endmodule

// File: tb/tb_q_tile_scheduler.sv
// Directed bench for q_tile_scheduler with small memory, dual-bank buffer and PE-array models.
module tb_q_tile_scheduler;

  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] q_base_addr;
  logic [15:0] num_q_tiles;
  logic        busy, done, order_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic [63:0] mem_rsp_data;
  logic        buf_load_valid, buf_load_ready;
  logic [63:0] buf_load_data;
  logic        buf_compute_start, buf_compute_done;
  logic        buf_bank_full, buf_bank_active, buf_active_bank_id;
  logic        pe_tile_start, pe_tile_done;
  logic [15:0] pe_tile_idx;

  int checks = 0;
  int errors = 0;

  q_tile_scheduler #(
    .NUM_PES    (4),
    .Q_WIDTH    (64),
    .ADDR_WIDTH (32),
    .TILE_W     (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .q_base_addr        (q_base_addr),
    .num_q_tiles        (num_q_tiles),
    .busy               (busy),
    .done               (done),
    .order_err          (order_err),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_rsp_valid      (mem_rsp_valid),
    .mem_rsp_ready      (mem_rsp_ready),
    .mem_rsp_data       (mem_rsp_data),
    .buf_load_valid     (buf_load_valid),
    .buf_load_ready     (buf_load_ready),
    .buf_load_data      (buf_load_data),
    .buf_compute_start  (buf_compute_start),
    .buf_compute_done   (buf_compute_done),
    .buf_bank_full      (buf_bank_full),
    .buf_bank_active    (buf_bank_active),
    .buf_active_bank_id (buf_active_bank_id),
    .pe_tile_start      (pe_tile_start),
    .pe_tile_done       (pe_tile_done),
    .pe_tile_idx        (pe_tile_idx)
  );

  always #5 clk = ~clk;

  logic [57:0] all_outs;
  assign all_outs = {busy, done, order_err, mem_req_valid, mem_req_addr, mem_rsp_ready,
                     buf_load_valid, buf_compute_start, buf_compute_done, pe_tile_start,
                     pe_tile_idx};

  // Memory model: in-order responses, data tagged with the request address.
  logic [31:0] addr_log [256];
  logic [7:0]  req_wr = 8'd0;
  logic [7:0]  rsp_rd = 8'd0;
  assign mem_rsp_valid = (rsp_rd != req_wr);
  assign mem_rsp_data  = {32'hC0DE0000, addr_log[rsp_rd]};

  always @(posedge clk) begin
    if (rst) begin
      rsp_rd <= req_wr;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        addr_log[req_wr] <= mem_req_addr;
        req_wr <= req_wr + 8'd1;
      end
      if (mem_rsp_valid && mem_rsp_ready) rsp_rd <= rsp_rd + 8'd1;
    end
  end

  // Dual-bank buffer model.
  logic full [2];
  int   fill_cnt [2];
  logic fb, cb, bank_active, flip;
  assign buf_load_ready     = !full[fb];
  assign buf_bank_full      = full[cb];
  assign buf_bank_active    = bank_active;
  assign buf_active_bank_id = cb ^ flip;

  always @(posedge clk) begin
    if (rst) begin
      full[0] <= 1'b0; full[1] <= 1'b0;
      fill_cnt[0] <= 0; fill_cnt[1] <= 0;
      fb <= 1'b0; cb <= 1'b0; bank_active <= 1'b0;
    end else begin
      if (buf_load_valid && buf_load_ready) begin
        if (fill_cnt[fb] == NP - 1) begin
          fill_cnt[fb] <= 0;
          full[fb] <= 1'b1;
          fb <= ~fb;
        end else begin
          fill_cnt[fb] <= fill_cnt[fb] + 1;
        end
      end
      if (buf_compute_start) bank_active <= 1'b1;
      if (buf_compute_done) begin
        full[cb] <= 1'b0;
        cb <= ~cb;
        bank_active <= 1'b0;
      end
    end
  end

  // PE-array model: done pulse pe_delay cycles after a launch.
  logic pe_auto = 1'b0, pe_pending = 1'b0, pe_extra;
  int   pe_cnt = 0, pe_delay;
  assign pe_tile_done = pe_auto | pe_extra;

  always @(posedge clk) begin
    pe_auto <= 1'b0;
    if (rst) begin
      pe_pending <= 1'b0;
    end else if (pe_tile_start) begin
      pe_pending <= 1'b1;
      pe_cnt <= pe_delay;
    end else if (pe_pending) begin
      if (pe_cnt <= 1) begin
        pe_auto <= 1'b1;
        pe_pending <= 1'b0;
      end else begin
        pe_cnt <= pe_cnt - 1;
      end
    end
  end

  // Event recorder.
  logic        mon_clr;
  int          cyc = 0;
  int          m_req, m_viol, m_load, m_data_err, m_cstart, m_rel, m_req_at_rel, m_launch, m_done;
  int          full_cyc, cstart_cyc, launch_cyc, last_pe_done, rel_cyc, done_cyc;
  logic        have_full;
  logic [15:0] idx_log [16];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || mon_clr) begin
      m_req <= 0; m_viol <= 0; m_load <= 0; m_data_err <= 0; m_cstart <= 0; m_rel <= 0;
      m_req_at_rel <= -1; m_launch <= 0; m_done <= 0; have_full <= 1'b0;
      full_cyc <= 0; cstart_cyc <= 0; launch_cyc <= 0; last_pe_done <= 0;
      rel_cyc <= 0; done_cyc <= 0;
    end else begin
      if (mem_req_valid && mem_req_ready) m_req <= m_req + 1;
      if (mem_req_valid && ((m_req / NP) - m_rel) >= 2) m_viol <= m_viol + 1;
      if (buf_load_valid && buf_load_ready) begin
        m_load <= m_load + 1;
        if (buf_load_data !== {32'hC0DE0000, addr_log[rsp_rd]}) m_data_err <= m_data_err + 1;
      end
      if (buf_bank_full && !have_full) begin
        have_full <= 1'b1;
        full_cyc <= cyc;
      end
      if (buf_compute_start) begin
        if (m_cstart == 0) cstart_cyc <= cyc;
        m_cstart <= m_cstart + 1;
      end
      if (buf_compute_done) begin
        if (m_rel == 0) m_req_at_rel <= m_req;
        m_rel <= m_rel + 1;
        rel_cyc <= cyc;
      end
      if (pe_tile_start) begin
        if (m_launch < 16) idx_log[m_launch] <= pe_tile_idx;
        if (m_launch == 0) launch_cyc <= cyc;
        m_launch <= m_launch + 1;
      end
      if (pe_tile_done) last_pe_done <= cyc;
      if (done) begin
        m_done <= m_done + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic clear_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  // Returns at the negedge of cycle T+1 after a start sampled at T.
  task automatic start_job(input logic [31:0] base, input logic [15:0] n);
    @(negedge clk);
    start = 1'b1;
    q_base_addr = base;
    num_q_tiles = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_launch(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (pe_tile_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs !== 58'd0) begin
      errors++;
      $display("FAIL reset_outs: got %h expected 0", all_outs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_outs !== 58'd0) begin
      errors++;
      $display("FAIL idle_outs: got %h expected 0", all_outs);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] jb;
    clear_mon();
    pe_delay = 2;
    jb = req_wr;
    start_job(32'h1000, 16'd3);
    checks++;
    if ({busy, mem_req_valid, mem_req_addr} !== {2'b11, 32'h1000}) begin
      errors++;
      $display("FAIL start_latency: got busy=%0b valid=%0b addr=%h expected 1 1 00001000",
               busy, mem_req_valid, mem_req_addr);
    end
    wait_idle(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: got busy=1 expected 0");
    end
    checks++;
    if (m_req !== 12) begin
      errors++;
      $display("FAIL basic_req_count: got %0d expected 12", m_req);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (addr_log[8'(int'(jb) + i)] !== 32'h1000 + 32'(8 * i)) begin
        errors++;
        $display("FAIL basic_addr[%0d]: got %h expected %h", i, addr_log[8'(int'(jb) + i)],
                 32'h1000 + 32'(8 * i));
      end
    end
    checks++;
    if (m_launch !== 3) begin
      errors++;
      $display("FAIL basic_launches: got %0d expected 3", m_launch);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (idx_log[i] !== 16'(i)) begin
        errors++;
        $display("FAIL basic_idx[%0d]: got %0d expected %0d", i, idx_log[i], i);
      end
    end
    checks++;
    if ({m_done, m_cstart, m_rel, m_load} !== {32'd1, 32'd3, 32'd3, 32'd12}) begin
      errors++;
      $display("FAIL basic_pulses: got done=%0d cstart=%0d rel=%0d load=%0d expected 1 3 3 12",
               m_done, m_cstart, m_rel, m_load);
    end
    checks++;
    if (m_data_err !== 0) begin
      errors++;
      $display("FAIL basic_load_data: got %0d bad rows expected 0", m_data_err);
    end
    checks++;
    if (order_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_order_err: got %0b expected 0", order_err);
    end
    checks++;
    if (cstart_cyc !== full_cyc + 1 || launch_cyc !== full_cyc + 2) begin
      errors++;
      $display("FAIL full_to_launch: got cstart=+%0d launch=+%0d expected +1 +2",
               cstart_cyc - full_cyc, launch_cyc - full_cyc);
    end
    checks++;
    if (rel_cyc !== last_pe_done + 1 || done_cyc !== last_pe_done + 2) begin
      errors++;
      $display("FAIL pe_done_to_done: got rel=+%0d done=+%0d expected +1 +2",
               rel_cyc - last_pe_done, done_cyc - last_pe_done);
    end
  endtask

  task automatic test_credit();
    bit ok;
    clear_mon();
    pe_delay = 50;
    start_job(32'h2000, 16'd3);
    wait_idle(1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL credit_timeout: got busy=1 expected 0");
    end
    checks++;
    if (m_req_at_rel !== 8) begin
      errors++;
      $display("FAIL credit_rows_before_release: got %0d expected 8", m_req_at_rel);
    end
    checks++;
    if (m_viol !== 0) begin
      errors++;
      $display("FAIL credit_overissue: got %0d cycles expected 0", m_viol);
    end
    checks++;
    if (m_req !== 12 || m_done !== 1) begin
      errors++;
      $display("FAIL credit_totals: got req=%0d done=%0d expected 12 1", m_req, m_done);
    end
  endtask

  task automatic test_zero_tiles();
    clear_mon();
    start_job(32'h3000, 16'd0);
    checks++;
    if ({done, busy, mem_req_valid} !== 3'b110) begin
      errors++;
      $display("FAIL zero_t1: got done=%0b busy=%0b valid=%0b expected 1 1 0",
               done, busy, mem_req_valid);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL zero_t2: got done=%0b busy=%0b expected 0 0", done, busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({m_req, m_cstart, m_rel, m_launch} !== 128'd0) begin
      errors++;
      $display("FAIL zero_no_traffic: got req=%0d cstart=%0d rel=%0d launch=%0d expected 0",
               m_req, m_cstart, m_rel, m_launch);
    end
  endtask

  task automatic test_ignored();
    bit ok;
    clear_mon();
    pe_delay = 2;
    start_job(32'h4000, 16'd2);
    pe_extra = 1'b1;
    @(negedge clk);
    pe_extra = 1'b0;
    start = 1'b1;
    q_base_addr = 32'h9000;
    num_q_tiles = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ignored_timeout: got busy=1 expected 0");
    end
    checks++;
    if (m_req !== 8 || addr_log[req_wr - 8'd1] !== 32'h4038) begin
      errors++;
      $display("FAIL ignored_requests: got %0d last=%h expected 8 last=00004038",
               m_req, addr_log[req_wr - 8'd1]);
    end
    checks++;
    if ({m_launch, m_rel, m_done} !== {32'd2, 32'd2, 32'd1}) begin
      errors++;
      $display("FAIL ignored_sequence: got launch=%0d rel=%0d done=%0d expected 2 2 1",
               m_launch, m_rel, m_done);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    clear_mon();
    pe_delay = 40;
    start_job(32'h5000, 16'd3);
    wait_launch(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_launch_timeout: got no pe_tile_start expected one");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs !== 58'd0) begin
      errors++;
      $display("FAIL midrst_outs: got %h expected 0", all_outs);
    end
    rst = 1'b0;
    clear_mon();
    pe_delay = 2;
    start_job(32'h6000, 16'd2);
    wait_idle(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_rerun_timeout: got busy=1 expected 0");
    end
    checks++;
    if ({m_req, m_load, m_launch, m_done} !== {32'd8, 32'd8, 32'd2, 32'd1}) begin
      errors++;
      $display("FAIL midrst_rerun: got req=%0d load=%0d launch=%0d done=%0d expected 8 8 2 1",
               m_req, m_load, m_launch, m_done);
    end
    checks++;
    if ({idx_log[0], idx_log[1], order_err} !== {16'd0, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL midrst_idx: got %0d %0d err=%0b expected 0 1 0",
               idx_log[0], idx_log[1], order_err);
    end
  endtask

  task automatic test_order_err();
    bit ok;
    clear_mon();
    pe_delay = 2;
    flip = 1'b1;
    start_job(32'h7000, 16'd2);
    wait_launch(200, ok);
    @(negedge clk);
    flip = 1'b0;
    checks++;
    if (!ok || order_err !== 1'b1) begin
      errors++;
      $display("FAIL order_set: got %0b expected 1", order_err);
    end
    wait_idle(400, ok);
    checks++;
    if (!ok || order_err !== 1'b1) begin
      errors++;
      $display("FAIL order_sticky: got %0b busy=%0b expected 1 0", order_err, busy);
    end
    start_job(32'h8000, 16'd0);
    checks++;
    if (order_err !== 1'b0) begin
      errors++;
      $display("FAIL order_clear: got %0b expected 0", order_err);
    end
    wait_idle(10, ok);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    q_base_addr = '0;
    num_q_tiles = '0;
    mem_req_ready = 1'b1;
    pe_extra = 1'b0;
    flip = 1'b0;
    pe_delay = 2;
    mon_clr = 1'b0;
    test_reset();
    test_basic();
    test_credit();
    test_zero_tiles();
    test_ignored();
    test_reset_mid_run();
    test_order_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/q_tile_scheduler.md
# q_tile_scheduler

Sequences Q-tile traffic through the dual-banked Q-vector buffer. It issues row reads to the memory adapter, streams responses into the buffer's fill bank, latches full banks for compute, launches the PE array per Q tile, and releases each bank once the PEs report the tile done. It sits between the top-level attention controller, the memory adapter, the Q buffer and the PE array.

## Interface
- NUM_PES, default `NUM_PES: Q rows per tile; one row per PE.
- Q_WIDTH, default `MAX_EMBEDDING_DIM*`INTEGER_WIDTH: bits per Q row; must be a multiple of 8.
- ADDR_WIDTH, default 32: byte address width.
- TILE_W, default 16: width of the tile count and index.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; latches q_base_addr and num_q_tiles; ignored while busy.
- q_base_addr  in  ADDR_WIDTH  byte address of row 0.
- num_q_tiles  in  TILE_W  number of tiles to process.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- order_err  out  1  sticky bank-order mismatch; cleared on accepted start.
- mem_req_valid / mem_req_ready  out / in  1  row read request handshake.
- mem_req_addr  out  ADDR_WIDTH  row byte address.
- mem_rsp_valid / mem_rsp_ready  in / out  1  row response handshake.
- mem_rsp_data  in  Q_WIDTH  row data.
- buf_load_valid / buf_load_ready  out / in  1  buffer load handshake.
- buf_load_data  out  Q_WIDTH  row to buffer.
- buf_compute_start / buf_compute_done  out  1  buffer bank latch / release pulses.
- buf_bank_full, buf_bank_active, buf_active_bank_id  in  1  buffer status.
- pe_tile_start  out  1  pulse; Q rows on the buffer output are valid.
- pe_tile_done  in  1  pulse from the PE array.
- pe_tile_idx  out  TILE_W  index of the current tile.

## Operation
- Reset value of every output is 0. rst clears both FSMs, all counters and order_err. The buffer shares rst, so a reset mid-job abandons all state with no drain.
- Fetch FSM: F_IDLE -> F_REQ on accepted start when num_q_tiles != 0.
  - In F_REQ, mem_req_valid = 1 while tiles_req - tiles_ret < 2.
  - When the credit check fails, mem_req_valid = 0 and the FSM holds in F_REQ.
  - Request address: mem_req_addr = base + rows_req * (Q_WIDTH/8), wrapping mod 2^ADDR_WIDTH.
  - Each accepted request increments rows_req. The last row of a tile increments tiles_req.
  - When tiles_req reaches num_q_tiles, go to F_IDLE.
- Response path (combinational):
  - buf_load_valid = mem_rsp_valid & busy.
  - buf_load_data = mem_rsp_data.
  - mem_rsp_ready = buf_load_ready & busy.
  - Responses while idle are not accepted.
- Compute FSM: C_IDLE, C_WAIT_FULL, C_LATCH, C_LAUNCH, C_RUN, C_RELEASE, C_FINISH.
  - C_IDLE -> C_WAIT_FULL on accepted start. If num_q_tiles == 0, go to C_FINISH instead.
  - C_WAIT_FULL -> C_LATCH when buf_bank_full = 1.
  - C_LATCH: buf_compute_start = 1 -> C_LAUNCH.
  - C_LAUNCH: pe_tile_start = 1. Compare buf_active_bank_id with tiles_ret[0]; a mismatch sets order_err. -> C_RUN.
  - C_RUN: wait for pe_tile_done -> C_RELEASE. pe_tile_done in any other state is ignored.
  - C_RELEASE: buf_compute_done = 1; tiles_ret++. Go to C_FINISH if the new tiles_ret == num_q_tiles, else C_WAIT_FULL.
  - C_FINISH: done = 1 -> C_IDLE.
- busy = 1 from the cycle after an accepted start until the cycle after C_FINISH.
- pe_tile_idx = tiles_ret, stable from C_LAUNCH through C_RELEASE.
- Credit is computed from registered counts. A retire in cycle N frees credit in N+1 (one-cycle conservative).
- Counter widths:
  - tiles_req and tiles_ret: TILE_W.
  - rows_req: TILE_W + $clog2(NUM_PES).
  - No overflow for num_q_tiles up to 2^TILE_W - 1.

## Timing
- Accepted start at cycle T:
  - busy = 1 and mem_req_valid = 1 at T+1.
  - With num_q_tiles = 0: done at T+1, busy = 0 at T+2.
- buf_bank_full sampled 1 in C_WAIT_FULL at cycle C:
  - buf_compute_start at C+1.
  - pe_tile_start at C+2.
  - C_RUN from C+3.
- pe_tile_done at cycle D (in C_RUN):
  - buf_compute_done at D+1.
  - Then either C_WAIT_FULL at D+2, or done at D+2 and busy = 0 at D+3.
- All outputs are registered-state decodes, except the combinational response pass-through.
- Simultaneous request-accept and release is legal; each counter updates independently.

## Structure
- Shared design package holds the fetch_state_t and compute_state_t enums and the row-bytes constant Q_WIDTH/8.
- One sub-module, q_fetch_agu, holds the fetch FSM, row/tile request counters and address generator. Its inputs are tiles_ret and the job config; its output is the request channel.
- The top module holds the compute FSM, the response pass-through and order_err.

## Test plan
- NUM_PES = 4, num_q_tiles = 3, base 0x1000, Q_WIDTH 64 -> 12 requests at 0x1000, 0x1008 … 0x1058; three pe_tile_start pulses with idx 0, 1, 2; one done; order_err = 0.
- mem_req_ready held 1 and pe_tile_done delayed 50 cycles -> at most 8 rows requested before the first buf_compute_done; no request while tiles_req - tiles_ret = 2.
- num_q_tiles = 0 -> done at T+1, no mem_req_valid, no buffer pulses.
- start pulsed while busy, and pe_tile_done pulsed in C_WAIT_FULL -> both ignored; sequence and counts unchanged.
- rst asserted mid-C_RUN -> next cycle all outputs 0 and FSMs idle; a new start then completes a 2-tile job normally.
- buf_active_bank_id forced to 1 at the first C_LAUNCH -> order_err = 1 and held until the next accepted start.
